// File: rtl/neuron_scheduler.sv
// Time-multiplexed LIF neuron controller: one shared update datapath walks
// N_NEURONS virtual neurons in index order, one per cycle, per start pulse.
module neuron_scheduler #(
    parameter int                 N_NEURONS = 4,
    parameter int                 IDX_W     = 2,
    parameter logic signed [15:0] LEAK      = 16'sd1,
    parameter logic signed [15:0] VTH       = 16'sd30,
    parameter logic signed [15:0] RESET_V   = 16'sd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           a1,
    input  logic [7:0]           a2,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [7:0]           cfg_q1,
    input  logic [7:0]           cfg_q2,
    input  logic [7:0]           cfg_bias,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [15:0]          rd_vp,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spikes
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]     idx_reg;
    logic signed [7:0]    a1_reg, a2_reg;
    logic signed [7:0]    q1_reg   [N_NEURONS];
    logic signed [7:0]    q2_reg   [N_NEURONS];
    logic signed [7:0]    bias_reg [N_NEURONS];
    logic signed [15:0]   vp_reg   [N_NEURONS];
    logic [N_NEURONS-1:0] stage_reg, stage_next;
    logic [N_NEURONS-1:0] spikes_reg;
    logic [15:0]          rd_vp_reg;

    logic                 last_idx;
    logic signed [15:0]   cur_vp, prod1, prod2, sat_v, leak_v, vp_new;
    logic signed [17:0]   sum;
    logic                 fire;

    assign last_idx = (idx_reg == IDX_W'(N_NEURONS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_idx) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Update for the neuron selected by idx_reg; 18 bits cannot overflow here.
    always_comb begin
        cur_vp = vp_reg[idx_reg];
        prod1  = 16'(a1_reg) * 16'(q1_reg[idx_reg]);
        prod2  = 16'(a2_reg) * 16'(q2_reg[idx_reg]);
        sum    = 18'(cur_vp) + 18'(prod1) + 18'(prod2) + 18'(bias_reg[idx_reg]);
        if (sum > 18'sd32767) begin
            sat_v = 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            sat_v = 16'sh8000;
        end else begin
            sat_v = sum[15:0];
        end
        leak_v = (sat_v > 16'sd0) ? (sat_v - LEAK) : sat_v;
        fire   = (leak_v > VTH);
        vp_new = fire ? RESET_V : leak_v;
    end

    // Staging vector with the current neuron's spike merged in, so the
    // last neuron's bit reaches spikes on the same edge that enters DONE.
    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_stage
            assign stage_next[gi] = (idx_reg == IDX_W'(gi)) ? fire : stage_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg    <= '0;
            a1_reg     <= '0;
            a2_reg     <= '0;
            stage_reg  <= '0;
            spikes_reg <= '0;
            rd_vp_reg  <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                q1_reg[i]   <= '0;
                q2_reg[i]   <= '0;
                bias_reg[i] <= '0;
                vp_reg[i]   <= '0;
            end
        end else begin
            rd_vp_reg <= vp_reg[rd_addr];
            if (state_reg == IDLE) begin
                if (cfg_we) begin
                    q1_reg[cfg_addr]   <= cfg_q1;
                    q2_reg[cfg_addr]   <= cfg_q2;
                    bias_reg[cfg_addr] <= cfg_bias;
                end
                if (start) begin
                    a1_reg  <= a1;
                    a2_reg  <= a2;
                    idx_reg <= '0;
                end
            end
            if (state_reg == RUN) begin
                vp_reg[idx_reg] <= vp_new;
                stage_reg       <= stage_next;
                idx_reg         <= idx_reg + 1'b1;
                if (last_idx) spikes_reg <= stage_next;
            end
        end
    end

    assign rd_vp  = rd_vp_reg;
    assign spikes = spikes_reg;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: directed scenarios plus random
// timesteps compared against an arithmetic LIF model.
module tb_neuron_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, start, cfg_we;
    logic [7:0]  a1, a2, cfg_q1, cfg_q2, cfg_bias;
    logic [1:0]  cfg_addr, rd_addr;
    logic [15:0] rd_vp;
    logic        busy, done;
    logic [3:0]  spikes;

    int checks = 0;
    int errors = 0;

    int         m_vp [N];
    int         m_q1 [N];
    int         m_q2 [N];
    int         m_b  [N];
    logic [3:0] m_spk;

    always #5 clk = ~clk;

    neuron_scheduler #(
        .N_NEURONS(4), .IDX_W(2), .LEAK(16'sd1), .VTH(16'sd30), .RESET_V(16'sd0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .a1(a1), .a2(a2),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_q1(cfg_q1), .cfg_q2(cfg_q2),
        .cfg_bias(cfg_bias), .rd_addr(rd_addr), .rd_vp(rd_vp),
        .busy(busy), .done(done), .spikes(spikes)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_vp[i] = 0; m_q1[i] = 0; m_q2[i] = 0; m_b[i] = 0;
        end
        m_spk = '0;
    endfunction

    function automatic void model_cfg(int n, int q1, int q2, int b);
        m_q1[n] = q1; m_q2[n] = q2; m_b[n] = b;
    endfunction

    function automatic void model_step(int x1, int x2);
        int s;
        for (int i = 0; i < N; i++) begin
            s = m_vp[i] + x1 * m_q1[i] + x2 * m_q2[i] + m_b[i];
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            if (s > 0) s = s - 1;
            if (s > 30) begin
                m_spk[i] = 1'b1;
                m_vp[i]  = 0;
            end else begin
                m_spk[i] = 1'b0;
                m_vp[i]  = s;
            end
        end
    endfunction

    task automatic do_cfg(int n, int q1, int q2, int b);
        cfg_we   = 1'b1;
        cfg_addr = 2'(n);
        cfg_q1   = 8'(q1);
        cfg_q2   = 8'(q2);
        cfg_bias = 8'(b);
        tick();
        cfg_we = 1'b0;
        model_cfg(n, q1, q2, b);
    endtask

    task automatic check_vps(string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = 2'(i);
            tick();
            checks++;
            if (rd_vp !== 16'(m_vp[i])) begin
                errors++;
                $display("FAIL %s_vp%0d: got %0d expected %0d", tag, i, $signed(rd_vp), m_vp[i]);
            end
        end
    endtask

    // Pulses start (plus any cfg_we already set up by the caller), scrambles
    // a1/a2 during RUN, and checks latency, spikes and the done pulse width.
    task automatic run_step(int x1, int x2, string tag);
        int n;
        start = 1'b1;
        a1    = 8'(x1);
        a2    = 8'(x2);
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
        a1     = 8'($urandom);
        a2     = 8'($urandom);
        model_step(x1, x2);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != N) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", tag, n, N);
        end
        checks++;
        if (spikes !== m_spk) begin
            errors++;
            $display("FAIL %s_spikes: got %b expected %b", tag, spikes, m_spk);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done: got done=%b busy=%b expected 0 0", tag, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
        a1 = '0; a2 = '0; cfg_addr = '0; cfg_q1 = '0; cfg_q2 = '0; cfg_bias = '0; rd_addr = '0;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || spikes !== 4'b0 || rd_vp !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b spikes=%b rd_vp=%h expected 0 0 0000 0000",
                     busy, done, spikes, rd_vp);
        end
        check_vps("reset");
    endtask

    task automatic test_integrate();
        for (int i = 0; i < N; i++) do_cfg(i, 2, 3, 1);
        for (int s = 0; s < 3; s++) begin
            run_step(4, 2, "integrate");
            check_vps("integrate");
        end
        checks++;
        if (spikes !== 4'b1111) begin
            errors++;
            $display("FAIL integrate_final_spikes: got %b expected 1111", spikes);
        end
    endtask

    task automatic test_reset_midrun();
        bit saw_done;
        rd_addr = 2'd0;
        start = 1'b1; a1 = 8'd4; a2 = 8'd2;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || spikes !== 4'b0 || rd_vp !== 16'h0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b spikes=%b rd_vp=%h expected 0 0 0000 0000",
                     busy, done, spikes, rd_vp);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrun_no_done: got done pulse expected none");
        end
        check_vps("midrun");
    endtask

    task automatic test_threshold();
        do_cfg(0, 0, 0, 31);
        run_step(0, 0, "thresh_eq");
        check_vps("thresh_eq");
        checks++;
        if (spikes[0] !== 1'b0) begin
            errors++;
            $display("FAIL thresh_eq_nospike: got %b expected 0", spikes[0]);
        end
        do_cfg(0, 0, 0, 2);
        run_step(0, 0, "thresh_over");
        check_vps("thresh_over");
    endtask

    task automatic test_neg_sat();
        do_cfg(1, 127, 0, -128);
        for (int s = 0; s < 3; s++) begin
            run_step(-128, 0, "negsat");
            check_vps("negsat");
        end
        checks++;
        if (m_vp[1] != -32768 || spikes[1] !== 1'b0) begin
            errors++;
            $display("FAIL negsat_floor: got vp=%0d spike=%b expected -32768 0", m_vp[1], spikes[1]);
        end
    endtask

    task automatic test_cfg_start();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_q1 = 8'd0; cfg_q2 = 8'd0; cfg_bias = 8'd40;
        model_cfg(2, 0, 0, 40);
        run_step(5, 5, "cfgstart");
        check_vps("cfgstart");
        checks++;
        if (spikes[2] !== 1'b1) begin
            errors++;
            $display("FAIL cfgstart_spike2: got %b expected 1", spikes[2]);
        end
    endtask

    task automatic test_timing();
        start = 1'b1; a1 = 8'd3; a2 = 8'd1;
        tick();
        start = 1'b0;
        model_step(3, 1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL timing_t1: got busy=%b done=%b expected 1 0", busy, done);
        end
        tick();
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0;
        cfg_q1 = 8'd100; cfg_q2 = 8'd100; cfg_bias = 8'd100;
        for (int k = 2; k <= N; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL timing_t%0d: got busy=%b done=%b expected 1 0", k, busy, done);
            end
            tick();
            start = 1'b0; cfg_we = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || spikes !== m_spk) begin
            errors++;
            $display("FAIL timing_done: got busy=%b done=%b spikes=%b expected 1 1 %b",
                     busy, done, spikes, m_spk);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timing_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timing_no_queue: got busy=%b expected 0", busy);
        end
        check_vps("timing");
        run_step(7, -3, "timing_cfg_ignored");
        check_vps("timing_cfg_ignored");
    endtask

    task automatic test_random();
        int x1, x2;
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 3) == 0)
                    do_cfg($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
                           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
                else
                    do_cfg($urandom_range(0, 3), int'($urandom_range(0, 30)) - 15,
                           int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 40)) - 20);
            end
            x1 = int'($urandom_range(0, 255)) - 128;
            x2 = int'($urandom_range(0, 255)) - 128;
            run_step(x1, x2, "random");
            check_vps("random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_integrate();
        test_reset_midrun();
        test_threshold();
        test_neg_sat();
        test_cfg_start();
        test_timing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
